main_memory_responder: RTL

//  Memory-side responder for the cache miss/eviction interface. Serves line requests from D$ and I$
//  (memory_request_t: addr, is_store, data) and returns line data or a bus error.

---
 rtl/main_memory_responder.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/main_memory_responder.sv
// Modelled main memory below the D$ and I$: round-robin arbitration between the two ports,
// one request in flight, fixed MEM_LATENCY. Define MEM_ERR_CHECK_EN for out-of-range bus errors.
`ifndef DCACHE_LINE_WIDTH
`define DCACHE_LINE_WIDTH 128
`endif

package main_memory_responder_pkg;
  localparam int ADDR_W     = 32;
  localparam int MEM_LINE_W = `DCACHE_LINE_WIDTH;

  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic                  is_store;
    logic [MEM_LINE_W-1:0] data;
  } memory_request_t;

  typedef enum logic {
    PORT_D = 1'b0,
    PORT_I = 1'b1
  } port_e;
endpackage

module main_memory_responder
  import main_memory_responder_pkg::*;
#(
  parameter int MEM_LATENCY     = 10,
  parameter int MEM_DEPTH_LINES = 256,
  parameter int LINE_W          = MEM_LINE_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dreq_valid,
  input  memory_request_t   dreq_info,
  input  logic              ireq_valid,
  input  memory_request_t   ireq_info,
  output logic              drsp_valid,
  output logic [LINE_W-1:0] drsp_data,
  output logic              drsp_bus_error,
  output logic              irsp_valid,
  output logic [LINE_W-1:0] irsp_data,
  output logic              irsp_bus_error,
  output logic              busy
);

  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int LIDX_W = ADDR_W - OFF_W;
  localparam int IDX_W  = (MEM_DEPTH_LINES > 1) ? $clog2(MEM_DEPTH_LINES) : 1;
  localparam int CNT_W  = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state;
  logic [CNT_W-1:0] cnt;
  port_e           rr_ptr;
  port_e           port_q;
  memory_request_t req_q;
  logic            mask_d;
  logic            mask_i;

  logic [LINE_W-1:0] mem [MEM_DEPTH_LINES];

  logic              d_cand;
  logic              i_cand;
  logic              accept;
  logic              grant_i;
  port_e             port_now;
  memory_request_t   req_now;
  logic              enter_resp;
  logic [LIDX_W-1:0] line_now;
  logic [IDX_W-1:0]  idx_now;
  logic              err_now;
  logic [LINE_W-1:0] rd_data;
  logic              unused_offset;

  // The request is taken straight from the winning port in IDLE (needed when MEM_LATENCY==1),
  // and from the latched copy afterwards.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
    d_cand     = dreq_valid && !mask_d;
    i_cand     = ireq_valid && !mask_i;
    accept     = (state == IDLE) && (d_cand || i_cand);
    grant_i    = i_cand && (!d_cand || (rr_ptr == PORT_I));
    port_now   = port_q;
    req_now    = req_q;
    if (state == IDLE) begin
      port_now = grant_i ? PORT_I : PORT_D;
      req_now  = grant_i ? ireq_info : dreq_info;
    end
    enter_resp = reset &&
                 ((accept && (MEM_LATENCY == 1)) ||
                  ((state == WAIT) && (cnt == CNT_W'(1))));
  end

  assign line_now      = req_now.addr[ADDR_W-1:OFF_W];
  assign unused_offset = ^req_now.addr[OFF_W-1:0];

`ifdef MEM_ERR_CHECK_EN
  assign err_now = (line_now >= LIDX_W'(MEM_DEPTH_LINES));
  assign idx_now = line_now[IDX_W-1:0];
`else
  assign err_now = 1'b0;
  assign idx_now = IDX_W'(line_now % LIDX_W'(MEM_DEPTH_LINES));
`endif

  assign rd_data = (req_now.is_store || err_now) ? '0 : mem[idx_now];

  // NOTE: the memory array has no reset; contents survive reset like real DRAM, and a
  // resettable array would not map onto RAM macros.
  always_ff @(posedge clock) begin
    if (enter_resp && req_now.is_store && !err_now) begin
      mem[idx_now] <= req_now.data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      rr_ptr         <= PORT_D;
      port_q         <= PORT_D;
      req_q          <= '0;
      mask_d         <= 1'b0;
      mask_i         <= 1'b0;
      busy           <= 1'b0;
      drsp_valid     <= 1'b0;
      drsp_data      <= '0;
      drsp_bus_error <= 1'b0;
      irsp_valid     <= 1'b0;
      irsp_data      <= '0;
      irsp_bus_error <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every register
      // samples the pre-edge values regardless of statement order.
      drsp_valid     <= 1'b0;
      drsp_data      <= '0;
      drsp_bus_error <= 1'b0;
      irsp_valid     <= 1'b0;
      irsp_data      <= '0;
      irsp_bus_error <= 1'b0;

      // The port just served still shows valid for one cycle after its response.
      mask_d <= (state == RESP) && (port_q == PORT_D);
      mask_i <= (state == RESP) && (port_q == PORT_I);

      unique case (state)
        IDLE: begin
          if (accept) begin
            req_q  <= req_now;
            port_q <= port_now;
            busy   <= 1'b1;
            cnt    <= CNT_W'(MEM_LATENCY - 1);
            state  <= (MEM_LATENCY == 1) ? RESP : WAIT;
            if (d_cand && i_cand) begin
              rr_ptr <= (rr_ptr == PORT_D) ? PORT_I : PORT_D;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (enter_resp) begin
        if (port_now == PORT_D) begin
          drsp_valid     <= 1'b1;
          drsp_data      <= rd_data;
          drsp_bus_error <= err_now;
        end else begin
          irsp_valid     <= 1'b1;
          irsp_data      <= rd_data;
          irsp_bus_error <= err_now;
        end
      end
    end
  end

endmodule
